alu_issue_seq: RTL and testbench

Sequencing front-end for the single-cycle CPU's combinational ALU. It accepts an operation request over a valid/ready handshake and decodes ALUOp/funct into the 4-bit ALU control code. It drives the ALU's operand and control inputs from registered copies, waits a programmable settle time, and captures result and zero into a response register. The response is held on a second valid/ready handshake. Used by the multi-cycle datapath and by bench harnesses that exercise the ALU as a transaction target.

---
 rtl/alu_issue_seq.sv | 139 +++++++++++++
 tb/tb_alu_issue_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: valid/ready sequencer around a combinational ALU.
// Optional illegal-funct trap: define ALU_SEQ_ILLEGAL_TRAP_EN.
module alu_issue_seq #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_aluop_i,
  input  logic [5:0]        req_funct_i,
  input  logic [DATA_W-1:0] req_src1_i,
  input  logic [DATA_W-1:0] req_src2_i,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic [3:0]        alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_result_o,
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  output logic              rsp_illegal_o,
`endif
  output logic              rsp_zero_o
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_SLT = 4'b0111;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] dec_ctrl;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic       dec_illegal;
`endif

  assign req_ready_o = (state == IDLE);

  // Decode ALUOp/funct into the ALU control code.
  always_comb begin
    dec_ctrl = C_ADD;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    dec_illegal = 1'b0;
`endif
    unique case (req_aluop_i)
      2'b00: dec_ctrl = C_ADD;
      2'b01: dec_ctrl = C_SUB;
      2'b11: dec_ctrl = C_SLT;
      default: begin
        unique case (req_funct_i)
          6'b100000: dec_ctrl = C_ADD;
          6'b100010: dec_ctrl = C_SUB;
          6'b100100: dec_ctrl = C_AND;
          6'b100101: dec_ctrl = C_OR;
          6'b101010: dec_ctrl = C_SLT;
          default: begin
            // Unknown funct falls back to add unless trapped.
            dec_ctrl = C_ADD;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            dec_illegal = 1'b1;
`endif
          end
        endcase
      end
    endcase
  end

  // Sequencer FSM: accept, settle, capture, hold response.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      alu_src1_o   <= '0;
      alu_src2_o   <= '0;
      alu_ctrl_o   <= C_ADD;
      rsp_valid_o  <= 1'b0;
      rsp_result_o <= '0;
      rsp_zero_o   <= 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      rsp_illegal_o <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            alu_src1_o <= req_src1_i;
            alu_src2_o <= req_src2_i;
            alu_ctrl_o <= dec_ctrl;
            cnt        <= CNT_LOAD;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            rsp_illegal_o <= dec_illegal;
            if (dec_illegal) begin
              state        <= RESP;
              rsp_valid_o  <= 1'b1;
              rsp_result_o <= '0;
              rsp_zero_o   <= 1'b0;
            end else begin
              state <= EXEC;
            end
`else
            state <= EXEC;
`endif
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            rsp_result_o <= alu_result_i;
            rsp_zero_o   <= (alu_ctrl_o == C_SUB) & alu_zero_i;
            rsp_valid_o  <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: directed checks of alu_issue_seq.
// Two instances: EXEC_CYCLES=1 (a) and EXEC_CYCLES=4 (b).
module tb_alu_issue_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic force_zero;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  logic        rv_a, rr_a, pv_a, pr_a, pz_a, az_a;
  logic [1:0]  aop_a;
  logic [5:0]  fn_a;
  logic [31:0] s1_a, s2_a, as1_a, as2_a, ares_a, pres_a;
  logic [3:0]  actl_a;
  logic        rv_b, rr_b, pv_b, pr_b, pz_b, az_b;
  logic [1:0]  aop_b;
  logic [5:0]  fn_b;
  logic [31:0] s1_b, s2_b, as1_b, as2_b, ares_b, pres_b;
  logic [3:0]  actl_b;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic        pill_a, pill_b;
`endif

  function automatic logic [31:0] alu_f(
    input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0010: alu_f = a + b;
      4'b0110: alu_f = a - b;
      4'b0000: alu_f = a & b;
      4'b0001: alu_f = a | b;
      4'b0111: alu_f = {31'd0, $signed(a) < $signed(b)};
      default: alu_f = 32'd0;
    endcase
  endfunction

  always_comb begin
    ares_a = alu_f(actl_a, as1_a, as2_a);
    az_a   = (ares_a == 32'd0) | force_zero;
    ares_b = alu_f(actl_b, as1_b, as2_b);
    az_b   = (ares_b == 32'd0) | force_zero;
  end

  alu_issue_seq #(.EXEC_CYCLES(1), .DATA_W(32)) dut_a (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(rv_a), .req_ready_o(rr_a),
    .req_aluop_i(aop_a), .req_funct_i(fn_a),
    .req_src1_i(s1_a), .req_src2_i(s2_a),
    .alu_src1_o(as1_a), .alu_src2_o(as2_a),
    .alu_ctrl_o(actl_a),
    .alu_result_i(ares_a), .alu_zero_i(az_a),
    .rsp_valid_o(pv_a), .rsp_ready_i(pr_a),
    .rsp_result_o(pres_a),
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    .rsp_illegal_o(pill_a),
`endif
    .rsp_zero_o(pz_a)
  );

  alu_issue_seq #(.EXEC_CYCLES(4), .DATA_W(32)) dut_b (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(rv_b), .req_ready_o(rr_b),
    .req_aluop_i(aop_b), .req_funct_i(fn_b),
    .req_src1_i(s1_b), .req_src2_i(s2_b),
    .alu_src1_o(as1_b), .alu_src2_o(as2_b),
    .alu_ctrl_o(actl_b),
    .alu_result_i(ares_b), .alu_zero_i(az_b),
    .rsp_valid_o(pv_b), .rsp_ready_i(pr_b),
    .rsp_result_o(pres_b),
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    .rsp_illegal_o(pill_b),
`endif
    .rsp_zero_o(pz_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request on instance a; returns 1ns after the accept edge.
  task automatic issue_a(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (rr_a !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (rr_a !== 1'b1) begin
      fails++;
      $display("FAIL issue_ready got %b want 1", rr_a);
    end
    aop_a = op; fn_a = fn; s1_a = a; s2_a = b;
    rv_a = 1'b1;
    tick();
    rv_a = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (rr_a !== 1'b1) begin fails++; $display("FAIL rst_ready got %b want 1", rr_a); end
    tests++; if (pv_a !== 1'b0) begin fails++; $display("FAIL rst_rspv got %b want 0", pv_a); end
    tests++; if (pres_a !== 32'd0) begin fails++; $display("FAIL rst_res got %h want 0", pres_a); end
    tests++; if (pz_a !== 1'b0) begin fails++; $display("FAIL rst_zero got %b want 0", pz_a); end
    tests++; if (actl_a !== 4'b0010) begin fails++; $display("FAIL rst_ctrl got %b want 0010", actl_a); end
    tests++; if (as1_a !== 32'd0 || as2_a !== 32'd0) begin fails++; $display("FAIL rst_src got %h %h want 0 0", as1_a, as2_a); end
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    tests++; if (pill_a !== 1'b0) begin fails++; $display("FAIL rst_ill got %b want 0", pill_a); end
`endif
  endtask

  task automatic test_add();
    issue_a(2'b10, 6'b100000, 32'd5, 32'hFFFFFFF9);
    tests++; if (rr_a !== 1'b0) begin fails++; $display("FAIL add_busy got %b want 0", rr_a); end
    tests++; if (actl_a !== 4'b0010) begin fails++; $display("FAIL add_ctrl got %b want 0010", actl_a); end
    tests++; if (as1_a !== 32'd5) begin fails++; $display("FAIL add_src1 got %h want 5", as1_a); end
    tests++; if (pv_a !== 1'b0) begin fails++; $display("FAIL add_early got %b want 0", pv_a); end
    tick();
    tests++; if (pv_a !== 1'b1) begin fails++; $display("FAIL add_rspv got %b want 1", pv_a); end
    tests++; if (pres_a !== 32'hFFFFFFFE) begin fails++; $display("FAIL add_res got %h want fffffffe", pres_a); end
    tests++; if (pz_a !== 1'b0) begin fails++; $display("FAIL add_zero got %b want 0", pz_a); end
    tick();
    tests++; if (pv_a !== 1'b0 || rr_a !== 1'b1) begin fails++; $display("FAIL add_idle got v%b r%b want v0 r1", pv_a, rr_a); end
    tests++; if (as1_a !== 32'd5) begin fails++; $display("FAIL add_hold got %h want 5", as1_a); end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    tests++; if (as1_a !== 32'd0 || as2_a !== 32'd0) begin fails++; $display("FAIL arst_src got %h %h want 0 0", as1_a, as2_a); end
    tests++; if (rr_a !== 1'b1 || actl_a !== 4'b0010) begin fails++; $display("FAIL arst_ctl got r%b c%b want r1 c0010", rr_a, actl_a); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sub_zero();
    issue_a(2'b01, 6'b000000, 32'h1234, 32'h1234);
    tests++; if (actl_a !== 4'b0110) begin fails++; $display("FAIL sub_ctrl got %b want 0110", actl_a); end
    tick();
    tests++; if (pres_a !== 32'd0) begin fails++; $display("FAIL sub_res got %h want 0", pres_a); end
    tests++; if (pz_a !== 1'b1) begin fails++; $display("FAIL sub_zero got %b want 1", pz_a); end
    tick();
    force_zero = 1'b1;
    issue_a(2'b10, 6'b100100, 32'h1234, 32'h1234);
    tests++; if (actl_a !== 4'b0000) begin fails++; $display("FAIL and_ctrl got %b want 0000", actl_a); end
    tick();
    tests++; if (pres_a !== 32'h1234) begin fails++; $display("FAIL and_res got %h want 1234", pres_a); end
    tests++; if (pz_a !== 1'b0) begin fails++; $display("FAIL and_zero got %b want 0", pz_a); end
    force_zero = 1'b0;
    tick();
  endtask

  task automatic test_slt_or_hold();
    issue_a(2'b11, 6'b000000, 32'hFFFFFFFF, 32'd1);
    tests++; if (actl_a !== 4'b0111) begin fails++; $display("FAIL slt_ctrl got %b want 0111", actl_a); end
    tick();
    tests++; if (pres_a !== 32'd1) begin fails++; $display("FAIL slt_res got %h want 1", pres_a); end
    tick();
    pr_a = 1'b0;
    issue_a(2'b10, 6'b100101, 32'hF0, 32'h0F);
    tick();
    tests++; if (pv_a !== 1'b1 || pres_a !== 32'hFF) begin fails++; $display("FAIL or_res got v%b %h want v1 ff", pv_a, pres_a); end
    aop_a = 2'b00; fn_a = 6'd0; s1_a = 32'd99; s2_a = 32'd1;
    rv_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (pv_a !== 1'b1 || pres_a !== 32'hFF || rr_a !== 1'b0 || as1_a !== 32'hF0) begin
        fails++;
        $display("FAIL hold%0d got v%b %h r%b s%h want v1 ff r0 sf0", i, pv_a, pres_a, rr_a, as1_a);
      end
    end
    pr_a = 1'b1;
    tick();
    tests++; if (pv_a !== 1'b0 || rr_a !== 1'b1) begin fails++; $display("FAIL hold_rel got v%b r%b want v0 r1", pv_a, rr_a); end
    tick();
    rv_a = 1'b0;
    tests++; if (as1_a !== 32'd99) begin fails++; $display("FAIL hold_next got %h want 63", as1_a); end
    tick();
    tests++; if (pv_a !== 1'b1 || pres_a !== 32'd100) begin fails++; $display("FAIL hold_res got v%b %h want v1 64", pv_a, pres_a); end
    tick();
  endtask

  task automatic test_exec4();
    aop_b = 2'b00; fn_b = 6'd0; s1_b = 32'd2; s2_b = 32'd3;
    rv_b = 1'b1;
    tick();
    rv_b = 1'b0;
    tests++; if (rr_b !== 1'b0) begin fails++; $display("FAIL e4_busy got %b want 0", rr_b); end
    for (int i = 1; i < 4; i++) begin
      tick();
      tests++;
      if (pv_b !== 1'b0) begin fails++; $display("FAIL e4_early%0d got %b want 0", i, pv_b); end
    end
    tick();
    tests++; if (pv_b !== 1'b1 || pres_b !== 32'd5) begin fails++; $display("FAIL e4_rsp got v%b %h want v1 5", pv_b, pres_b); end
    tick();
    tests++; if (rr_b !== 1'b1) begin fails++; $display("FAIL e4_idle got %b want 1", rr_b); end
  endtask

  task automatic test_reset_mid_exec();
    aop_b = 2'b01; s1_b = 32'd9; s2_b = 32'd4;
    rv_b = 1'b1;
    tick();
    rv_b = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    tests++; if (pv_b !== 1'b0 || rr_b !== 1'b1) begin fails++; $display("FAIL mrst_st got v%b r%b want v0 r1", pv_b, rr_b); end
    tests++; if (actl_b !== 4'b0010 || as1_b !== 32'd0) begin fails++; $display("FAIL mrst_alu got c%b s%h want c0010 s0", actl_b, as1_b); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++;
      if (pv_b !== 1'b0 || rr_b !== 1'b1) begin fails++; $display("FAIL mrst_quiet%0d got v%b r%b want v0 r1", i, pv_b, rr_b); end
    end
  endtask

  task automatic test_illegal();
    issue_a(2'b10, 6'b111111, 32'd3, 32'd4);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    tests++; if (pv_a !== 1'b1 || pill_a !== 1'b1) begin fails++; $display("FAIL ill_rsp got v%b i%b want v1 i1", pv_a, pill_a); end
    tests++; if (pres_a !== 32'd0 || pz_a !== 1'b0) begin fails++; $display("FAIL ill_res got %h z%b want 0 z0", pres_a, pz_a); end
    tick();
    issue_a(2'b00, 6'd0, 32'd1, 32'd1);
    tests++; if (pill_a !== 1'b0) begin fails++; $display("FAIL ill_clr got %b want 0", pill_a); end
    tick();
    tests++; if (pres_a !== 32'd2) begin fails++; $display("FAIL ill_next got %h want 2", pres_a); end
`else
    tests++; if (actl_a !== 4'b0010 || pv_a !== 1'b0) begin fails++; $display("FAIL ill_ctrl got c%b v%b want c0010 v0", actl_a, pv_a); end
    tick();
    tests++; if (pv_a !== 1'b1 || pres_a !== 32'd7) begin fails++; $display("FAIL ill_sum got v%b %h want v1 7", pv_a, pres_a); end
`endif
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; force_zero = 1'b0;
    rv_a = 1'b0; aop_a = 2'b00; fn_a = 6'd0; s1_a = '0; s2_a = '0; pr_a = 1'b1;
    rv_b = 1'b0; aop_b = 2'b00; fn_b = 6'd0; s1_b = '0; s2_b = '0; pr_b = 1'b1;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_add();
    test_async_reset();
    tick();
    test_sub_zero();
    test_slt_or_hold();
    test_exec4();
    test_reset_mid_exec();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
